sum_nbit_serial: RTL and testbench



---
 rtl/sum_nbit_serial_if.sv | 35 +++
 rtl/sum_nbit_serial.sv | 99 +++++++++
 tb/tb_sum_nbit_serial.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_nbit_serial_if.sv
// Operand/result handshake bundle for sum_nbit_serial.
// The sub signal exists only when SUM_SUB_EN is defined.
interface sum_nbit_serial_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   o;
`ifdef SUM_SUB_EN
    logic             sub;

    modport master (
        output in_valid, x0, x1, cin, sub, out_ready,
        input  in_ready, out_valid, o
    );
    modport slave (
        input  in_valid, x0, x1, cin, sub, out_ready,
        output in_ready, out_valid, o
    );
`else
    modport master (
        output in_valid, x0, x1, cin, out_ready,
        input  in_ready, out_valid, o
    );
    modport slave (
        input  in_valid, x0, x1, cin, out_ready,
        output in_ready, out_valid, o
    );
`endif
endinterface

// File: rtl/sum_nbit_serial.sv
// Digit-serial handshaked adder: WIDTH-bit operands summed DIGIT bits per clock.
// Define SUM_SUB_EN to add the sub input (x0 - x1 via ~x1 + 1).
module sum_nbit_serial #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIGIT = 1
) (
    input logic                 clk,
    input logic                 rst,
    sum_nbit_serial_if.slave    bus
);
    localparam int unsigned NumDig = WIDTH / DIGIT;
    localparam int unsigned CntW   = (NumDig > 1) ? $clog2(NumDig) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH:0]    r_o;

    logic [31:0]       w_base;
    logic [DIGIT-1:0]  w_a_dig;
    logic [DIGIT-1:0]  w_b_dig;
    logic [DIGIT:0]    w_sum;
    logic              w_last;
    logic              w_sub;

`ifdef SUM_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    // One ripple slice, steered to the current digit position.
    assign w_base  = 32'(r_cnt) * DIGIT;
    assign w_a_dig = r_a[w_base +: DIGIT];
    assign w_b_dig = r_b[w_base +: DIGIT];
    assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    assign w_last  = (r_cnt == CntW'(NumDig - 1));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.o         = r_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_o         <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= StAdd;
                        r_in_ready <= 1'b0;
                        r_a        <= bus.x0;
                        // Subtraction: two's complement of x1, carry-in forced to 1.
                        r_b        <= w_sub ? ~bus.x1 : bus.x1;
                        r_carry    <= w_sub | bus.cin;
                        r_cnt      <= '0;
                        r_o        <= '0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                StAdd: begin
                    r_o[w_base +: DIGIT] <= w_sum[DIGIT-1:0];
                    r_carry              <= w_sum[DIGIT];
                    if (w_last) begin
                        r_o[WIDTH]  <= w_sum[DIGIT];
                        r_state     <= StDone;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_nbit_serial.sv
// Directed bench for sum_nbit_serial: DIGIT=1 and DIGIT=2 instances share stimulus;
// an 8-bit single-step instance checks subtraction when SUM_SUB_EN is defined.
module tb_sum_nbit_serial;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sum_nbit_serial_if #(.WIDTH(4)) bus1 ();
    sum_nbit_serial_if #(.WIDTH(4)) bus2 ();

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.x0        = bus1.x0;
    assign bus2.x1        = bus1.x1;
    assign bus2.cin       = bus1.cin;
    assign bus2.out_ready = bus1.out_ready;
`ifdef SUM_SUB_EN
    assign bus2.sub       = bus1.sub;
`endif

    sum_nbit_serial #(.WIDTH(4), .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sum_nbit_serial #(.WIDTH(4), .DIGIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

`ifdef SUM_SUB_EN
    sum_nbit_serial_if #(.WIDTH(8)) bus3 ();
    sum_nbit_serial #(.WIDTH(8), .DIGIT(8)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation on both 4-bit instances, check latency and result, then drain it.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [4:0] exp);
        int lat1 = -1;
        int lat2 = -1;
        bit rdy  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus1.in_ready && bus2.in_ready) begin
                rdy = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("in_ready before accept", 32'(rdy), 32'd1);
        bus1.x0       = a;
        bus1.x1       = b;
        bus1.cin      = c;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after capture: result must not follow them.
        bus1.in_valid = 1'b0;
        bus1.x0       = ~a;
        bus1.x1       = ~b;
        bus1.cin      = ~c;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (lat1 < 0 && bus1.out_valid) lat1 = cyc;
            if (lat2 < 0 && bus2.out_valid) lat2 = cyc;
            if (lat1 >= 0 && lat2 >= 0) break;
        end
        chk("latency digit1", 32'(lat1), 32'd4);
        chk("latency digit2", 32'(lat2), 32'd2);
        chk("sum digit1", 32'(bus1.o), 32'(exp));
        chk("sum digit2", 32'(bus2.o), 32'(exp));
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

`ifdef SUM_SUB_EN
    task automatic run_sub(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic c, input logic [8:0] exp);
        bus3.x0       = a;
        bus3.x1       = b;
        bus3.sub      = s;
        bus3.cin      = c;
        bus3.in_valid = 1'b1;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sub out_valid", 32'(bus3.out_valid), 32'd1);
        chk("sub result", 32'(bus3.o), 32'(exp));
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        bus3.out_ready = 1'b0;
    endtask
`endif

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'd7,  4'd8,  1'b0, 5'h0F};
        vecs[1] = '{4'd15, 4'd15, 1'b1, 5'h1F};
        vecs[2] = '{4'd0,  4'd0,  1'b0, 5'h00};
        vecs[3] = '{4'd0,  4'd0,  1'b1, 5'h01};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 5'h10};
        vecs[5] = '{4'd9,  4'd6,  1'b1, 5'h10};
        vecs[6] = '{4'd5,  4'd5,  1'b0, 5'h0A};
        vecs[7] = '{4'd15, 4'd1,  1'b0, 5'h10};
        vecs[8] = '{4'd3,  4'd12, 1'b0, 5'h0F};
        vecs[9] = '{4'd10, 4'd11, 1'b1, 5'h16};

        rst            = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.x0        = '0;
        bus1.x1        = '0;
        bus1.cin       = 1'b0;
        bus1.out_ready = 1'b0;
`ifdef SUM_SUB_EN
        bus1.sub       = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.x0        = '0;
        bus3.x1        = '0;
        bus3.cin       = 1'b0;
        bus3.sub       = 1'b0;
        bus3.out_ready = 1'b0;
`endif
        #1;
        chk("reset o", 32'(bus1.o), 32'd0);
        chk("reset out_valid", 32'(bus1.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus1.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset", 32'(bus1.in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(4'(a), 4'(b), 1'(c), 5'(a + b + c));
                end
            end
        end

        // Backpressure: hold result for 5 cycles while inputs wander.
        bus1.x0       = 4'd6;
        bus1.x1       = 4'd9;
        bus1.cin      = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus1.out_valid && bus2.out_valid) break;
            @(posedge clk); #1;
        end
        chk("bp out_valid", 32'(bus1.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus1.x0 = 4'(i);
            bus1.x1 = 4'(~i);
            @(posedge clk); #1;
            chk("bp hold o", 32'(bus1.o), 32'h0F);
            chk("bp hold out_valid", 32'(bus1.out_valid), 32'd1);
            chk("bp hold in_ready", 32'(bus1.in_ready), 32'd0);
            chk("bp hold o digit2", 32'(bus2.o), 32'h0F);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("bp out_valid drop", 32'(bus1.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp in_ready back", 32'(bus1.in_ready), 32'd1);
        chk("bp in_ready back digit2", 32'(bus2.in_ready), 32'd1);

        // Reset during the second ADD cycle.
        bus1.x0       = 4'd2;
        bus1.x1       = 4'd3;
        bus1.cin      = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort o", 32'(bus1.o), 32'd0);
        chk("abort out_valid", 32'(bus1.out_valid), 32'd0);
        chk("abort in_ready", 32'(bus1.in_ready), 32'd0);
        chk("abort o digit2", 32'(bus2.o), 32'd0);
        chk("abort out_valid digit2", 32'(bus2.out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no stale out_valid", 32'(bus1.out_valid), 32'd0);
            chk("no stale out_valid digit2", 32'(bus2.out_valid), 32'd0);
        end
        chk("abort in_ready back", 32'(bus1.in_ready), 32'd1);
        run_op(4'd2, 4'd3, 1'b0, 5'd5);

`ifdef SUM_SUB_EN
        run_sub(8'd3, 8'd5, 1'b1, 1'b0, 9'h0FE);
        run_sub(8'd5, 8'd3, 1'b1, 1'b0, 9'h102);
        run_sub(8'd7, 8'd8, 1'b0, 1'b1, 9'h010);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
